// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: issues paired imem requests (pc, pc+4) and tracks fetch/stall counts.
// Latency: imem_req/fetch_vld are combinational from state and this cycle's inputs.
// Backpressure: instBuffer_full or !imem_rdy holds pc; start/halt/flush suppress the write.
module ifu_fetch_ctrl #(
   parameter int                     PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
   parameter int                     CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sync_start_pulse,
   input  logic [PC_WIDTH-1:0]   start_pc,
   input  logic                  halt_req,
   input  logic                  bru_flush,
   input  logic [PC_WIDTH-1:0]   bru_target_pc,
   input  logic                  instBuffer_full,
   input  logic                  imem_rdy,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr_0,
   output logic [PC_WIDTH-1:0]   imem_addr_1,
   output logic                  fetch_vld,
   output logic [PC_WIDTH-1:0]   pc_out_0,
   output logic [PC_WIDTH-1:0]   pc_out_1,
   output logic                  unalign_pc_out_0,
   output logic                  unalign_pc_out_1,
   output logic [1:0]            fetch_state,
   output logic [CNT_WIDTH-1:0]  fetch_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [1:0]          state, state_nxt;
   logic [PC_WIDTH-1:0] pc, pc_nxt, pc_plus4;
   logic                stall_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE:  state_nxt = sync_start_pulse ? ST_FETCH : ST_IDLE;
         ST_HALT:  state_nxt = sync_start_pulse ? ST_FETCH : ST_HALT;
         ST_FETCH: begin
            if (sync_start_pulse)  state_nxt = ST_FETCH;
            else if (halt_req)     state_nxt = ST_HALT;
            else                   state_nxt = ST_FETCH;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Any redirect clears the buffer this cycle, so no write may land alongside it.
   always_comb begin
      imem_req  = (state == ST_FETCH) & ~instBuffer_full & ~sync_start_pulse
                  & ~halt_req & ~bru_flush;
      fetch_vld = imem_req & imem_rdy;
   end

   always_comb begin
      pc_nxt = pc;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (sync_start_pulse) pc_nxt = start_pc;
         end
         ST_FETCH: begin
            if (sync_start_pulse)  pc_nxt = start_pc;
            else if (halt_req)     pc_nxt = pc;
            else if (bru_flush)    pc_nxt = bru_target_pc;
            else if (fetch_vld)    pc_nxt = pc + PC_WIDTH'(8);
         end
         default:  pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_nxt;
      end
   end

   assign stall_inc = (state == ST_FETCH) & instBuffer_full;

   // Counters saturate rather than wrap; a start pulse clears them ahead of any increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else if (sync_start_pulse) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (fetch_vld && (fetch_cnt != {CNT_WIDTH{1'b1}}))
            fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
         if (stall_inc && (stall_cnt != {CNT_WIDTH{1'b1}}))
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end

   assign pc_plus4         = pc + PC_WIDTH'(4);
   assign imem_addr_0      = pc;
   assign imem_addr_1      = pc_plus4;
   assign pc_out_0         = pc;
   assign pc_out_1         = pc_plus4;
   assign unalign_pc_out_0 = |pc[1:0];
   assign unalign_pc_out_1 = |pc_plus4[1:0];
   assign fetch_state      = state;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: per-cycle vector table plus saturation and mid-fetch reset sequences.
module tb_ifu_fetch_ctrl;

   localparam int          PW  = 32;
   localparam int          CW  = 4;
   localparam logic [31:0] RPC = 32'h0000_1000;

   logic          clk;
   logic          rst_n;
   logic          sync_start_pulse;
   logic [31:0]   start_pc;
   logic          halt_req;
   logic          bru_flush;
   logic [31:0]   bru_target_pc;
   logic          instBuffer_full;
   logic          imem_rdy;
   logic          imem_req;
   logic [31:0]   imem_addr_0;
   logic [31:0]   imem_addr_1;
   logic          fetch_vld;
   logic [31:0]   pc_out_0;
   logic [31:0]   pc_out_1;
   logic          unalign_pc_out_0;
   logic          unalign_pc_out_1;
   logic [1:0]    fetch_state;
   logic [CW-1:0] fetch_cnt;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   ifu_fetch_ctrl #(.PC_WIDTH(PW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sync_start_pulse (sync_start_pulse),
      .start_pc         (start_pc),
      .halt_req         (halt_req),
      .bru_flush        (bru_flush),
      .bru_target_pc    (bru_target_pc),
      .instBuffer_full  (instBuffer_full),
      .imem_rdy         (imem_rdy),
      .imem_req         (imem_req),
      .imem_addr_0      (imem_addr_0),
      .imem_addr_1      (imem_addr_1),
      .fetch_vld        (fetch_vld),
      .pc_out_0         (pc_out_0),
      .pc_out_1         (pc_out_1),
      .unalign_pc_out_0 (unalign_pc_out_0),
      .unalign_pc_out_1 (unalign_pc_out_1),
      .fetch_state      (fetch_state),
      .fetch_cnt        (fetch_cnt),
      .stall_cnt        (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ss;
      logic [31:0] spc;
      logic        halt;
      logic        fl;
      logic [31:0] tpc;
      logic        full;
      logic        rdy;
      logic        e_req;
      logic        e_vld;
      logic [31:0] e_a0;
      logic [31:0] e_a1;
      logic [1:0]  e_st;
      logic        e_u0;
      logic        e_u1;
      logic [3:0]  e_fc;
      logic [3:0]  e_sc;
   } vec_t;

   vec_t vecs [25];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ss, input logic [31:0] spc, input logic halt,
                        input logic fl, input logic [31:0] tpc, input logic full,
                        input logic rdy);
      sync_start_pulse = ss;
      start_pc         = spc;
      halt_req         = halt;
      bru_flush        = fl;
      bru_target_pc    = tpc;
      instBuffer_full  = full;
      imem_rdy         = rdy;
   endtask

   initial begin
      //           ss spc           hlt fl tpc         full rdy  req vld a0            a1            st u0 u1 fc sc
      vecs[0]  = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    0, 0, 32'h1000,     32'h1004,     0, 0, 0, 0, 0};
      vecs[1]  = '{0, 32'h0,        1, 1, 32'h40,      0, 1,    0, 0, 32'h1000,     32'h1004,     0, 0, 0, 0, 0};
      vecs[2]  = '{1, 32'h100,      0, 0, 32'h0,       0, 1,    0, 0, 32'h1000,     32'h1004,     0, 0, 0, 0, 0};
      vecs[3]  = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h100,      32'h104,      1, 0, 0, 0, 0};
      vecs[4]  = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h108,      32'h10c,      1, 0, 0, 1, 0};
      vecs[5]  = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h110,      32'h114,      1, 0, 0, 2, 0};
      vecs[6]  = '{0, 32'h0,        0, 0, 32'h0,       0, 0,    1, 0, 32'h118,      32'h11c,      1, 0, 0, 3, 0};
      vecs[7]  = '{1, 32'h200,      0, 0, 32'h0,       0, 1,    0, 0, 32'h118,      32'h11c,      1, 0, 0, 3, 0};
      vecs[8]  = '{0, 32'h0,        0, 0, 32'h0,       1, 1,    0, 0, 32'h200,      32'h204,      1, 0, 0, 0, 0};
      vecs[9]  = '{0, 32'h0,        0, 0, 32'h0,       1, 1,    0, 0, 32'h200,      32'h204,      1, 0, 0, 0, 1};
      vecs[10] = '{0, 32'h0,        0, 0, 32'h0,       1, 1,    0, 0, 32'h200,      32'h204,      1, 0, 0, 0, 2};
      vecs[11] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h200,      32'h204,      1, 0, 0, 0, 3};
      vecs[12] = '{0, 32'h0,        0, 1, 32'h40,      0, 1,    0, 0, 32'h208,      32'h20c,      1, 0, 0, 1, 3};
      vecs[13] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h40,       32'h44,       1, 0, 0, 1, 3};
      vecs[14] = '{0, 32'h0,        1, 1, 32'h300,     0, 1,    0, 0, 32'h48,       32'h4c,       1, 0, 0, 2, 3};
      vecs[15] = '{0, 32'h0,        0, 1, 32'h500,     0, 1,    0, 0, 32'h48,       32'h4c,       2, 0, 0, 2, 3};
      vecs[16] = '{1, 32'h80,       0, 0, 32'h0,       0, 1,    0, 0, 32'h48,       32'h4c,       2, 0, 0, 2, 3};
      vecs[17] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h80,       32'h84,       1, 0, 0, 0, 0};
      vecs[18] = '{1, 32'hFFFFFFFC, 0, 0, 32'h0,       0, 1,    0, 0, 32'h88,       32'h8c,       1, 0, 0, 1, 0};
      vecs[19] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'hFFFFFFFC, 32'h0,        1, 0, 0, 0, 0};
      vecs[20] = '{1, 32'h102,      0, 0, 32'h0,       0, 1,    0, 0, 32'h4,        32'h8,        1, 0, 0, 1, 0};
      vecs[21] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    1, 1, 32'h102,      32'h106,      1, 1, 1, 0, 0};
      vecs[22] = '{0, 32'h0,        0, 0, 32'h0,       0, 0,    1, 0, 32'h10a,      32'h10e,      1, 1, 1, 1, 0};
      vecs[23] = '{0, 32'h0,        1, 0, 32'h0,       1, 1,    0, 0, 32'h10a,      32'h10e,      1, 1, 1, 1, 0};
      vecs[24] = '{0, 32'h0,        0, 0, 32'h0,       0, 1,    0, 0, 32'h10a,      32'h10e,      2, 1, 1, 1, 1};

      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 32'h0, 0, 1);
      repeat (3) @(negedge clk);
      #2;
      check("rst state", 32'(fetch_state), 32'd0);
      check("rst pc", imem_addr_0, RPC);
      check("rst req", 32'(imem_req), 32'd0);
      check("rst vld", 32'(fetch_vld), 32'd0);
      check("rst fcnt", 32'(fetch_cnt), 32'd0);
      check("rst scnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         drive(vecs[i].ss, vecs[i].spc, vecs[i].halt, vecs[i].fl, vecs[i].tpc,
               vecs[i].full, vecs[i].rdy);
         #2;
         check($sformatf("v%0d req", i),   32'(imem_req),         32'(vecs[i].e_req));
         check($sformatf("v%0d vld", i),   32'(fetch_vld),        32'(vecs[i].e_vld));
         check($sformatf("v%0d a0", i),    imem_addr_0,           vecs[i].e_a0);
         check($sformatf("v%0d a1", i),    imem_addr_1,           vecs[i].e_a1);
         check($sformatf("v%0d pc0", i),   pc_out_0,              vecs[i].e_a0);
         check($sformatf("v%0d pc1", i),   pc_out_1,              vecs[i].e_a1);
         check($sformatf("v%0d st", i),    32'(fetch_state),      32'(vecs[i].e_st));
         check($sformatf("v%0d un0", i),   32'(unalign_pc_out_0), 32'(vecs[i].e_u0));
         check($sformatf("v%0d un1", i),   32'(unalign_pc_out_1), 32'(vecs[i].e_u1));
         check($sformatf("v%0d fcnt", i),  32'(fetch_cnt),        32'(vecs[i].e_fc));
         check($sformatf("v%0d scnt", i),  32'(stall_cnt),        32'(vecs[i].e_sc));
      end

      // Counter saturation: 20 stall cycles then 20 fetches against a 4-bit counter.
      @(negedge clk);
      drive(1, 32'h0, 0, 0, 32'h0, 0, 0);
      @(negedge clk);
      drive(0, 32'h0, 0, 0, 32'h0, 1, 1);
      repeat (20) @(negedge clk);
      #2;
      check("sat scnt", 32'(stall_cnt), 32'd15);
      check("sat hold pc", imem_addr_0, 32'h0);
      check("sat full req", 32'(imem_req), 32'd0);
      drive(0, 32'h0, 0, 0, 32'h0, 0, 1);
      repeat (20) @(negedge clk);
      #2;
      check("sat fcnt", 32'(fetch_cnt), 32'd15);
      check("sat pc", imem_addr_0, 32'hA0);
      check("sat scnt kept", 32'(stall_cnt), 32'd15);

      // Reset asserted mid-cycle while fetching takes effect without a clock edge.
      check("pre-rst vld", 32'(fetch_vld), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid rst state", 32'(fetch_state), 32'd0);
      check("mid rst req", 32'(imem_req), 32'd0);
      check("mid rst vld", 32'(fetch_vld), 32'd0);
      check("mid rst pc", imem_addr_0, RPC);
      check("mid rst fcnt", 32'(fetch_cnt), 32'd0);
      check("mid rst scnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #2;
         check($sformatf("post rst vld%0d", k), 32'(fetch_vld), 32'd0);
         check($sformatf("post rst pc%0d", k), imem_addr_0, RPC);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
